// File: rtl/mem_pkg.sv
// Shared memory-port definitions: access sizes, handshake states and the
// byte-lane enable decoder also used by the core's load/store unit.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Size code 3 falls into the word case; low address bits beyond the access
  // size are ignored so misaligned accesses are silently aligned.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr;
      SZ_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/test_ram_model_if.sv
// SRAM-like request/response bus between a CPU data port and its memory.
interface test_ram_model_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok
  );
endinterface

// File: rtl/test_ram_model_ctrl.sv
// Fixed-latency handshake engine: one outstanding transaction, back-to-back
// acceptance on the completion cycle.
module test_ram_model_ctrl
  import mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  output logic o_accept,
  output logic o_addr_ok,
  output logic o_data_ok,
  output logic o_last
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam bit LAT1 = (LATENCY == 1);

  state_e        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          w_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // o_last flags the edge that enters the completion cycle, so the read word
  // can be registered in time to be valid alongside o_data_ok.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_done     = (r_state == ST_WAIT) && (r_cnt == '0);
    o_addr_ok  = (r_state == ST_IDLE) || w_done;
    o_accept   = i_req && o_addr_ok;
    o_data_ok  = w_done;
    o_last     = 1'b0;

    if (o_accept) begin
      w_state_nx = ST_WAIT;
      w_cnt_nx   = CNT_INIT;
    end else if (w_done) begin
      w_state_nx = ST_IDLE;
    end else if (r_state == ST_WAIT) begin
      w_cnt_nx = r_cnt - 1'b1;
    end

    if (LAT1) begin
      o_last = o_accept;
    end else begin
      o_last = (r_state == ST_WAIT) && (r_cnt == CW'(1));
    end
  end

endmodule

// File: rtl/test_ram_model.sv
// Word-organised data memory for simulation: byte-lane writes, full-word
// reads, fixed response latency. Contents are never reset.
module test_ram_model
  import mem_pkg::*;
#(
  parameter int DEPTH   = 65536,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  test_ram_model_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   ram [DEPTH];
  logic [31:0]   data_write;

  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic          w_accept;
  logic          w_addr_ok;
  logic          w_data_ok;
  logic          w_last;
  logic          w_unused;

  logic [AW-1:0] r_idx;
  logic          r_wr;
  logic [31:0]   r_rdata;

  assign data_write = bus.data_wdata;
  assign w_idx      = bus.data_addr[AW+1:2];
  assign w_be       = byte_en(bus.data_size, bus.data_addr[1:0]);
  assign w_unused   = ^bus.data_addr[31:AW+2];

  test_ram_model_ctrl #(
    .LATENCY (LATENCY)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .i_req     (bus.data_req),
    .o_accept  (w_accept),
    .o_addr_ok (w_addr_ok),
    .o_data_ok (w_data_ok),
    .o_last    (w_last)
  );

  assign bus.data_addr_ok = w_addr_ok;
  assign bus.data_data_ok = w_data_ok;
  assign bus.data_rdata   = r_rdata;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx <= w_idx;
      r_wr  <= bus.data_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && bus.data_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) ram[w_idx][b*8 +: 8] <= data_write[b*8 +: 8];
      end
    end
  end

  // With single-cycle latency the word is captured on the accepting edge from
  // the live address; otherwise from the pending index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (w_last) begin
      if (w_accept) begin
        if (!bus.data_wr) r_rdata <= ram[w_idx];
      end else if (!r_wr) begin
        r_rdata <= ram[r_idx];
      end
    end
  end

endmodule

// File: tb/tb_test_ram_model.sv
// Directed bench for test_ram_model: scoreboarded responses on a LATENCY=1
// instance plus cycle-exact handshake checks on a LATENCY=3 instance.
module tb_test_ram_model;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  test_ram_model_if bus ();
  test_ram_model_if bus3 ();

  test_ram_model #(.DEPTH(65536), .LATENCY(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  test_ram_model #(.DEPTH(1024), .LATENCY(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Response monitor: every completion must match the oldest accepted request.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.data_data_ok === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_data_ok", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk) chk(e.tag, bus.data_rdata, e.exp);
      end
    end
  end

  task automatic req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit check, input logic [31:0] exp,
                     input string tag);
    int k;
    bus.data_req   = 1'b1;
    bus.data_wr    = wr;
    bus.data_size  = size;
    bus.data_addr  = addr;
    bus.data_wdata = wdata;
    k = 0;
    @(negedge clk);
    while (bus.data_addr_ok !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
    else sb.push_back('{check, exp, tag});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.data_req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] b2b_exp [3];

  initial begin
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_size = 2'd0;
    bus.data_addr = '0; bus.data_wdata = '0;
    bus3.data_req = 1'b0; bus3.data_wr = 1'b0; bus3.data_size = 2'd2;
    bus3.data_addr = '0; bus3.data_wdata = '0;
    b2b_exp[0] = 32'h1000_0000;
    b2b_exp[1] = 32'h1111_1111;
    b2b_exp[2] = 32'h2222_2222;

    #2 rst = 1'b0;
    #10;
    chk("rst_data_ok",  {31'd0, bus.data_data_ok}, 32'd0);
    chk("rst_rdata",    bus.data_rdata, 32'd0);
    chk("rst_addr_ok",  {31'd0, bus.data_addr_ok}, 32'd1);
    chk("rst3_addr_ok", {31'd0, bus3.data_addr_ok}, 32'd1);

    dut.ram[32'h80] = 32'h1122_3344;
    dut.ram[0]      = b2b_exp[0];
    dut.ram[1]      = b2b_exp[1];
    dut.ram[2]      = b2b_exp[2];
    dut.ram[32'hC0] = 32'h0;
    dut3.ram[5]     = 32'hA5A5_0005;

    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Word write then read, completion one cycle after acceptance
    req(1'b1, 2'd2, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'h0, "w_word");
    req(1'b0, 2'd2, 32'h100, 32'h0, 1'b1, 32'hDEAD_BEEF, "r_word");
    bus.data_req = 1'b0;
    @(negedge clk);
    chk("r_word_latency", {31'd0, bus.data_data_ok}, 32'd1);
    @(posedge clk); #1;
    req(1'b0, 2'd2, 32'h0004_0100, 32'h0, 1'b1, 32'hDEAD_BEEF, "r_wrap");
    idle(2);

    // Byte and halfword lane writes
    req(1'b1, 2'd0, 32'h201, 32'hABAB_ABAB, 1'b0, 32'h0, "w_byte");
    req(1'b0, 2'd2, 32'h200, 32'h0, 1'b1, 32'h1122_AB44, "r_byte");
    idle(2);
    chk("peek_byte", dut.ram[32'h80], 32'h1122_AB44);
    req(1'b1, 2'd1, 32'h302, 32'hCAFE_0000, 1'b0, 32'h0, "w_half");
    req(1'b0, 2'd0, 32'h300, 32'h0, 1'b1, 32'hCAFE_0000, "r_half");
    req(1'b1, 2'd1, 32'h303, 32'h1234_5678, 1'b0, 32'h0, "w_half_odd");
    req(1'b0, 2'd2, 32'h300, 32'h0, 1'b1, 32'h1234_0000, "r_half_odd");
    req(1'b1, 2'd3, 32'h500, 32'h0BAD_F00D, 1'b0, 32'h0, "w_size3");
    req(1'b0, 2'd2, 32'h501, 32'h0, 1'b1, 32'h0BAD_F00D, "r_size3");
    req(1'b1, 2'd0, 32'h503, 32'hEE00_0000, 1'b0, 32'h0, "w_byte3");
    req(1'b0, 2'd1, 32'h502, 32'h0, 1'b1, 32'hEEAD_F00D, "r_byte3");
    idle(2);

    // Back-to-back reads with data_req held high
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_size = 2'd2;
    for (int i = 0; i < 3; i++) begin
      bus.data_addr = 32'(i * 4);
      @(negedge clk);
      chk("b2b_addr_ok", {31'd0, bus.data_addr_ok}, 32'd1);
      if (i > 0) chk("b2b_data_ok", {31'd0, bus.data_data_ok}, 32'd1);
      sb.push_back('{1'b1, b2b_exp[i], "r_b2b"});
      @(posedge clk); #1;
    end
    bus.data_req = 1'b0;
    @(negedge clk);
    chk("b2b_last_data_ok", {31'd0, bus.data_data_ok}, 32'd1);
    idle(2);

    // Reset right after a write is accepted: the write must persist
    req(1'b1, 2'd2, 32'h400, 32'h5566_7788, 1'b0, 32'h0, "w_pre_rst");
    rst = 1'b0;
    sb.delete();
    bus.data_req = 1'b0;
    @(negedge clk);
    chk("rst_w_data_ok", {31'd0, bus.data_data_ok}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    chk("peek_w_pre_rst", dut.ram[32'h100], 32'h5566_7788);

    // Reset while a read is pending: no completion, contents intact
    req(1'b0, 2'd2, 32'h100, 32'h0, 1'b1, 32'hDEAD_BEEF, "r_dropped");
    rst = 1'b0;
    sb.delete();
    bus.data_req = 1'b0;
    @(negedge clk);
    chk("rst_r_data_ok", {31'd0, bus.data_data_ok}, 32'd0);
    chk("rst_r_addr_ok", {31'd0, bus.data_addr_ok}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_data_ok", {31'd0, bus.data_data_ok}, 32'd0);
    chk("post_rst_addr_ok", {31'd0, bus.data_addr_ok}, 32'd1);
    @(posedge clk); #1;
    req(1'b0, 2'd2, 32'h100, 32'h0, 1'b1, 32'hDEAD_BEEF, "r_post_rst");
    idle(2);

    // LATENCY=3 handshake timing; data_req dropped while pending
    bus3.data_req = 1'b1; bus3.data_wr = 1'b0; bus3.data_addr = 32'h14;
    @(negedge clk);
    chk("l3_accept_addr_ok", {31'd0, bus3.data_addr_ok}, 32'd1);
    @(posedge clk); #1;
    bus3.data_req = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk("l3_wait_addr_ok", {31'd0, bus3.data_addr_ok}, 32'd0);
      chk("l3_wait_data_ok", {31'd0, bus3.data_data_ok}, 32'd0);
    end
    @(negedge clk);
    chk("l3_data_ok", {31'd0, bus3.data_data_ok}, 32'd1);
    chk("l3_rdata",   bus3.data_rdata, 32'hA5A5_0005);
    chk("l3_done_addr_ok", {31'd0, bus3.data_addr_ok}, 32'd1);
    @(negedge clk);
    chk("l3_pulse_end", {31'd0, bus3.data_data_ok}, 32'd0);
    chk("l3_rdata_hold", bus3.data_rdata, 32'hA5A5_0005);

    idle(3);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
